// File: rtl/xil_mem_pkg.sv
// Shared constants for the parametrised dual-port memory family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xil_mem_pkg;

  // Clear engine state encoding
  typedef enum logic {
    MEM_ST_CLEAR = 1'b0,
    MEM_ST_READY = 1'b1
  } mem_st_e;

  // Default word geometry, shared with the FIFO wrappers built on this memory
  localparam int MEM_LANES  = 2;
  localparam int MEM_LANE_W = 9;
  localparam int MEM_DW     = MEM_LANES * MEM_LANE_W;
  localparam int MEM_OREG   = 0;

endpackage

// File: rtl/xil_mem_dp_param_if.sv
// Access bundle for both ports of xil_mem_dp_param plus clear request/busy.
// Latency: n/a (wiring only).
// Backpressure: none; o_busy tells the master that accesses are being dropped.
interface xil_mem_dp_param_if
  import xil_mem_pkg::*;
#(
  parameter int ADR_W  = 10,
  parameter int LANES  = MEM_LANES,
  parameter int LANE_W = MEM_LANE_W
);
  localparam int DW = LANES * LANE_W;

  logic              i_clear;
  logic              o_busy;

  logic              i_en0;
  logic [LANES-1:0]  i_wen0;
  logic [ADR_W-1:0]  i_adr0;
  logic [DW-1:0]     i_wdata0;
  logic [DW-1:0]     o_rdata0;

  logic              i_en1;
  logic [LANES-1:0]  i_wen1;
  logic [ADR_W-1:0]  i_adr1;
  logic [DW-1:0]     i_wdata1;
  logic [DW-1:0]     o_rdata1;

  modport master (
    output i_clear,
    output i_en0, i_wen0, i_adr0, i_wdata0,
    output i_en1, i_wen1, i_adr1, i_wdata1,
    input  o_busy, o_rdata0, o_rdata1
  );

  modport slave (
    input  i_clear,
    input  i_en0, i_wen0, i_adr0, i_wdata0,
    input  i_en1, i_wen1, i_adr1, i_wdata1,
    output o_busy, o_rdata0, o_rdata1
  );

endinterface

// File: rtl/xil_mem_clear_fsm.sv
// Clear engine: zeroes every word after reset or on request by taking over port 0.
// Latency: 2**ADR_W cycles per clear; busy is registered.
// Backpressure: none; user accesses presented while busy are dropped, not queued.
module xil_mem_clear_fsm
  import xil_mem_pkg::*;
#(
  parameter int ADR_W = 10,
  parameter int LANES = MEM_LANES,
  parameter int DW    = MEM_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_req,
  output logic             busy,
  input  logic             usr_en,
  input  logic [LANES-1:0] usr_wen,
  input  logic [ADR_W-1:0] usr_adr,
  input  logic [DW-1:0]    usr_wdata,
  output logic             mem_en,
  output logic [LANES-1:0] mem_wen,
  output logic [ADR_W-1:0] mem_adr,
  output logic [DW-1:0]    mem_wdata
);

  mem_st_e          state;
  logic [ADR_W:0]   cnt;      // MSB set once the last address has been cleared
  logic [ADR_W:0]   cnt_nxt;

  assign cnt_nxt = cnt + 1'b1;

  // Sweep the counter through every address, then idle until a clear request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MEM_ST_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        MEM_ST_CLEAR: begin
          cnt <= cnt_nxt;
          if (cnt_nxt[ADR_W]) begin
            state <= MEM_ST_READY;
            busy  <= 1'b0;
          end
        end
        default: begin
          if (clear_req) begin
            state <= MEM_ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
      endcase
    end
  end

  // While clearing, port 0 writes zero to every lane at the counter address
  always_comb begin
    mem_en    = usr_en;
    mem_wen   = usr_wen;
    mem_adr   = usr_adr;
    mem_wdata = usr_wdata;
    if (busy) begin
      mem_en    = 1'b1;
      mem_wen   = '1;
      mem_adr   = cnt[ADR_W-1:0];
      mem_wdata = '0;
    end
  end

endmodule

// File: rtl/xil_mem_dp_param.sv
// Single-clock true dual-port RAM with lane write enables, write-first collision merge and clear engine.
// Latency: read data 1 cycle after access (OREG=0) or 2 cycles (OREG=1).
// Backpressure: none; accesses are dropped while o_busy is high and outputs hold.
module xil_mem_dp_param
  import xil_mem_pkg::*;
#(
  parameter int ADR_W  = 10,
  parameter int LANES  = MEM_LANES,
  parameter int LANE_W = MEM_LANE_W,
  parameter int OREG   = MEM_OREG
) (
  input  logic               clk,
  input  logic               rst_n,
  xil_mem_dp_param_if.slave  bus
);

  localparam int DW    = LANES * LANE_W;
  localparam int DEPTH = 1 << ADR_W;

  logic             busy;
  logic             a_en0;
  logic [LANES-1:0] a_wen0;
  logic [ADR_W-1:0] a_adr0;
  logic [DW-1:0]    a_wdata0;
  logic             a_en1;
  logic             usr_en0;
  logic [DW-1:0]    word0;
  logic [DW-1:0]    word1;
  logic [DW-1:0]    rd0_q;
  logic [DW-1:0]    rd1_q;
  logic [DW-1:0]    mem [DEPTH];

  xil_mem_clear_fsm #(
    .ADR_W (ADR_W),
    .LANES (LANES),
    .DW    (DW)
  ) u_clear (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (bus.i_clear),
    .busy      (busy),
    .usr_en    (bus.i_en0),
    .usr_wen   (bus.i_wen0),
    .usr_adr   (bus.i_adr0),
    .usr_wdata (bus.i_wdata0),
    .mem_en    (a_en0),
    .mem_wen   (a_wen0),
    .mem_adr   (a_adr0),
    .mem_wdata (a_wdata0)
  );

  assign bus.o_busy = busy;
  // Port 1 is simply shut off while the clear engine owns port 0
  assign a_en1   = bus.i_en1 & ~busy;
  assign usr_en0 = bus.i_en0 & ~busy;

  // Post-write word seen by each port; on a shared address port 0 lanes win, port 1 fills the rest
  always_comb begin
    word0 = mem[a_adr0];
    word1 = mem[a_adr1_w()];
    for (int k = 0; k < LANES; k++) begin
      if (a_en0 && a_wen0[k])
        word0[k*LANE_W +: LANE_W] = a_wdata0[k*LANE_W +: LANE_W];
      else if (a_en1 && bus.i_wen1[k] && (bus.i_adr1 == a_adr0))
        word0[k*LANE_W +: LANE_W] = bus.i_wdata1[k*LANE_W +: LANE_W];

      if (a_en0 && a_wen0[k] && (a_adr0 == bus.i_adr1))
        word1[k*LANE_W +: LANE_W] = a_wdata0[k*LANE_W +: LANE_W];
      else if (a_en1 && bus.i_wen1[k])
        word1[k*LANE_W +: LANE_W] = bus.i_wdata1[k*LANE_W +: LANE_W];
    end
  end

  function automatic logic [ADR_W-1:0] a_adr1_w();
    return bus.i_adr1;
  endfunction

  // Array update; on a collision both ports store the same merged word
  always_ff @(posedge clk) begin
    if (rst_n && a_en1 && (|bus.i_wen1))
      mem[bus.i_adr1] <= word1;
    if (rst_n && a_en0 && (|a_wen0))
      mem[a_adr0] <= word0;
  end

  // First read stage: capture the write-first word, hold when the port is idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      if (usr_en0)
        rd0_q <= word0;
      if (a_en1)
        rd1_q <= word1;
    end
  end

  if (OREG != 0) begin : g_oreg
    logic          vld0_q;
    logic          vld1_q;
    logic [DW-1:0] out0_q;
    logic [DW-1:0] out1_q;

    // Second read stage: follows stage one a cycle after each accepted read
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld0_q <= 1'b0;
        vld1_q <= 1'b0;
        out0_q <= '0;
        out1_q <= '0;
      end else begin
        vld0_q <= usr_en0;
        vld1_q <= a_en1;
        if (vld0_q)
          out0_q <= rd0_q;
        if (vld1_q)
          out1_q <= rd1_q;
      end
    end

    assign bus.o_rdata0 = out0_q;
    assign bus.o_rdata1 = out1_q;
  end else begin : g_direct
    assign bus.o_rdata0 = rd0_q;
    assign bus.o_rdata1 = rd1_q;
  end

endmodule

// File: tb/tb_xil_mem_dp_param.sv
// Bench for xil_mem_dp_param: OREG=0 and OREG=1 instances driven with identical stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_xil_mem_dp_param;

  localparam int AW    = 4;
  localparam int LN    = 2;
  localparam int LW    = 9;
  localparam int DW    = LN * LW;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference: word array, clear activity, expected outputs of both instances
  logic [DW-1:0] m [DEPTH];
  bit            mbusy;
  int            mcnt;
  logic [DW-1:0] ea0, ea1, eb0, eb1;

  always #5 clk = ~clk;

  xil_mem_dp_param_if #(.ADR_W(AW), .LANES(LN), .LANE_W(LW)) ifa ();
  xil_mem_dp_param_if #(.ADR_W(AW), .LANES(LN), .LANE_W(LW)) ifb ();

  xil_mem_dp_param #(.ADR_W(AW), .LANES(LN), .LANE_W(LW), .OREG(0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  xil_mem_dp_param #(.ADR_W(AW), .LANES(LN), .LANE_W(LW), .OREG(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  // One clock of stimulus on both instances, then advance the reference
  task automatic step(input logic en0, input logic [LN-1:0] wen0, input logic [AW-1:0] adr0,
                      input logic [DW-1:0] wd0, input logic en1, input logic [LN-1:0] wen1,
                      input logic [AW-1:0] adr1, input logic [DW-1:0] wd1, input logic clr);
    ifa.i_en0 = en0; ifa.i_wen0 = wen0; ifa.i_adr0 = adr0; ifa.i_wdata0 = wd0;
    ifa.i_en1 = en1; ifa.i_wen1 = wen1; ifa.i_adr1 = adr1; ifa.i_wdata1 = wd1;
    ifa.i_clear = clr;
    ifb.i_en0 = en0; ifb.i_wen0 = wen0; ifb.i_adr0 = adr0; ifb.i_wdata0 = wd0;
    ifb.i_en1 = en1; ifb.i_wen1 = wen1; ifb.i_adr1 = adr1; ifb.i_wdata1 = wd1;
    ifb.i_clear = clr;
    @(posedge clk);
    eb0 = ea0;
    eb1 = ea1;
    if (!rst_n) begin
      mbusy = 1'b1; mcnt = 0;
      ea0 = '0; ea1 = '0; eb0 = '0; eb1 = '0;
    end else if (mbusy) begin
      m[mcnt] = '0;
      mcnt++;
      if (mcnt == DEPTH) mbusy = 1'b0;
    end else begin
      // port 1 lanes land first so that port 0 lanes override them on a shared address
      if (en1) for (int k = 0; k < LN; k++) if (wen1[k]) m[adr1][k*LW +: LW] = wd1[k*LW +: LW];
      if (en0) for (int k = 0; k < LN; k++) if (wen0[k]) m[adr0][k*LW +: LW] = wd0[k*LW +: LW];
      if (en0) ea0 = m[adr0];
      if (en1) ea1 = m[adr1];
      if (clr) begin mbusy = 1'b1; mcnt = 0; end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    idle();
    idle();
    n_chk++;
    if (ifa.o_busy !== 1'b1 || ifb.o_busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy got %b/%b exp 1/1", ifa.o_busy, ifb.o_busy);
    end
    n_chk++;
    if (ifa.o_rdata0 !== '0 || ifa.o_rdata1 !== '0 || ifb.o_rdata0 !== '0 || ifb.o_rdata1 !== '0) begin
      n_fail++; $display("FAIL reset_rdata got %h %h %h %h exp 0", ifa.o_rdata0, ifa.o_rdata1, ifb.o_rdata0, ifb.o_rdata1);
    end
    rst_n = 1'b1;
    n = 0;
    do begin idle(); n++; end while (ifa.o_busy && n < 40);
    n_chk++;
    if (n !== DEPTH) begin
      n_fail++; $display("FAIL reset_busy_len got %0d exp %0d", n, DEPTH);
    end
    n_chk++;
    if (ifb.o_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_b got %b exp 0", ifb.o_busy);
    end
    step(1'b1, '0, 4'd9, '0, 1'b1, '0, 4'd2, '0, 1'b0);
    idle();
    n_chk++;
    if (ifb.o_rdata0 !== '0 || ifb.o_rdata1 !== '0 || ifa.o_rdata0 !== '0) begin
      n_fail++; $display("FAIL reset_read_zero got %h %h %h exp 0", ifa.o_rdata0, ifb.o_rdata0, ifb.o_rdata1);
    end
  endtask

  task automatic test_lane_write();
    step(1'b1, 2'b11, 4'd5, 18'h3FFFF, 1'b0, '0, '0, '0, 1'b0);
    n_chk++;
    if (ifa.o_rdata0 !== 18'h3FFFF) begin
      n_fail++; $display("FAIL lane_full_wr got %h exp %h", ifa.o_rdata0, 18'h3FFFF);
    end
    step(1'b0, '0, '0, '0, 1'b1, 2'b01, 4'd5, 18'h00155, 1'b0);
    // lane 1 keeps 0x1FF, lane 0 takes 0x155
    n_chk++;
    if (ifa.o_rdata1 !== 18'h3FF55 || ifa.o_rdata0 !== 18'h3FFFF) begin
      n_fail++; $display("FAIL lane_partial_wr got %h/%h exp 3ff55/3ffff", ifa.o_rdata1, ifa.o_rdata0);
    end
    step(1'b1, 2'b00, 4'd5, '0, 1'b0, '0, '0, '0, 1'b0);
    n_chk++;
    if (ifa.o_rdata0 !== 18'h3FF55 || ifb.o_rdata0 !== 18'h3FFFF) begin
      n_fail++; $display("FAIL lane_read_lat got a=%h b=%h exp a=3ff55 b=3ffff", ifa.o_rdata0, ifb.o_rdata0);
    end
    idle();
    n_chk++;
    if (ifb.o_rdata0 !== 18'h3FF55) begin
      n_fail++; $display("FAIL lane_read_lat2 got %h exp 3ff55", ifb.o_rdata0);
    end
  endtask

  task automatic test_collision();
    step(1'b1, 2'b01, 4'd7, 18'h12345, 1'b1, 2'b11, 4'd7, 18'h2ABCD, 1'b0);
    n_chk++;
    if (ifa.o_rdata0 !== 18'h2AB45 || ifa.o_rdata1 !== 18'h2AB45) begin
      n_fail++; $display("FAIL coll_fwd got %h/%h exp 2ab45", ifa.o_rdata0, ifa.o_rdata1);
    end
    idle();
    n_chk++;
    if (ifb.o_rdata0 !== 18'h2AB45 || ifb.o_rdata1 !== 18'h2AB45) begin
      n_fail++; $display("FAIL coll_fwd_b got %h/%h exp 2ab45", ifb.o_rdata0, ifb.o_rdata1);
    end
    step(1'b1, 2'b00, 4'd7, '0, 1'b0, '0, '0, '0, 1'b0);
    n_chk++;
    if (ifa.o_rdata0 !== 18'h2AB45) begin
      n_fail++; $display("FAIL coll_stored got %h exp 2ab45", ifa.o_rdata0);
    end
  endtask

  task automatic test_hold();
    logic [DW-1:0] v;
    step(1'b0, '0, '0, '0, 1'b1, 2'b11, 4'd3, 18'h1A2B3, 1'b0);
    step(1'b1, 2'b00, 4'd3, '0, 1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      v = DW'($urandom);
      step(1'b0, 2'b11, 4'd3, DW'($urandom), 1'b1, 2'b11, 4'd3, v, 1'b0);
      n_chk++;
      if (ifa.o_rdata0 !== 18'h1A2B3 || ifb.o_rdata0 !== 18'h1A2B3) begin
        n_fail++; $display("FAIL hold_rd0 cyc %0d got %h/%h exp 1a2b3", i, ifa.o_rdata0, ifb.o_rdata0);
      end
    end
    step(1'b1, 2'b00, 4'd3, '0, 1'b0, '0, '0, '0, 1'b0);
    n_chk++;
    if (ifa.o_rdata0 !== v) begin
      n_fail++; $display("FAIL hold_reenable got %h exp %h", ifa.o_rdata0, v);
    end
  endtask

  task automatic test_clear();
    int n;
    logic [DW-1:0] held1;
    for (int i = 0; i < 8; i++)
      step(1'b1, 2'b11, AW'(i), DW'($urandom), 1'b1, 2'b11, AW'(i + 8), DW'($urandom), 1'b0);
    step(1'b1, 2'b11, 4'd0, 18'h0ABCD, 1'b1, 2'b00, 4'd1, '0, 1'b1);
    held1 = ea1;
    n_chk++;
    if (ifa.o_rdata0 !== 18'h0ABCD || ifa.o_rdata1 !== held1) begin
      n_fail++; $display("FAIL clr_same_cycle got %h/%h exp 0abcd/%h", ifa.o_rdata0, ifa.o_rdata1, held1);
    end
    n = 0;
    do begin
      step(1'b1, LN'($urandom), AW'($urandom), DW'($urandom), 1'b1, LN'($urandom), AW'($urandom),
           DW'($urandom), 1'($urandom));
      n++;
      n_chk++;
      if (ifa.o_rdata0 !== 18'h0ABCD || ifa.o_rdata1 !== held1 || ifb.o_rdata0 !== 18'h0ABCD) begin
        n_fail++; $display("FAIL clr_hold cyc %0d got %h/%h/%h exp 0abcd/%h", n, ifa.o_rdata0, ifa.o_rdata1,
                           ifb.o_rdata0, held1);
      end
    end while (ifa.o_busy && n < 40);
    n_chk++;
    if (n !== DEPTH) begin
      n_fail++; $display("FAIL clr_busy_len got %0d exp %0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 2'b00, AW'(i), '0, 1'b1, 2'b00, AW'(DEPTH - 1 - i), '0, 1'b0);
      n_chk++;
      if (ifa.o_rdata0 !== '0 || ifa.o_rdata1 !== '0) begin
        n_fail++; $display("FAIL clr_zero adr %0d got %h/%h exp 0", i, ifa.o_rdata0, ifa.o_rdata1);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    step(1'b1, 2'b11, 4'd12, 18'h15A5A, 1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 7; i++) idle();
    n_chk++;
    if (ifa.o_busy !== 1'b1) begin
      n_fail++; $display("FAIL midclr_busy got %b exp 1", ifa.o_busy);
    end
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    n = 0;
    do begin idle(); n++; end while (ifa.o_busy && n < 40);
    n_chk++;
    if (n !== DEPTH) begin
      n_fail++; $display("FAIL midclr_busy_len got %0d exp %0d", n, DEPTH);
    end
    step(1'b1, 2'b00, 4'd12, '0, 1'b0, '0, '0, '0, 1'b0);
    n_chk++;
    if (ifa.o_rdata0 !== '0) begin
      n_fail++; $display("FAIL midclr_zero got %h exp 0", ifa.o_rdata0);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a0, a1;
    for (int c = 0; c < 400; c++) begin
      a0 = AW'($urandom);
      a1 = ($urandom_range(0, 1) == 0) ? a0 : AW'($urandom);
      step(1'($urandom), LN'($urandom), a0, DW'($urandom), 1'($urandom), LN'($urandom), a1,
           DW'($urandom), ($urandom_range(0, 63) == 0));
      n_chk++;
      if (ifa.o_rdata0 !== ea0 || ifa.o_rdata1 !== ea1) begin
        n_fail++; $display("FAIL rand_a cyc %0d got %h/%h exp %h/%h", c, ifa.o_rdata0, ifa.o_rdata1, ea0, ea1);
      end
      n_chk++;
      if (ifb.o_rdata0 !== eb0 || ifb.o_rdata1 !== eb1) begin
        n_fail++; $display("FAIL rand_b cyc %0d got %h/%h exp %h/%h", c, ifb.o_rdata0, ifb.o_rdata1, eb0, eb1);
      end
      n_chk++;
      if (ifa.o_busy !== mbusy || ifb.o_busy !== mbusy) begin
        n_fail++; $display("FAIL rand_busy cyc %0d got %b/%b exp %b", c, ifa.o_busy, ifb.o_busy, mbusy);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m[i] = DW'($urandom);
    mbusy = 1'b1; mcnt = 0;
    ea0 = '0; ea1 = '0; eb0 = '0; eb1 = '0;
    test_reset();
    test_lane_write();
    test_collision();
    test_hold();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
